life_grid_engine: RTL and testbench

- Parametrised successor to the fixed 16x16 Game of Life grid: ROWS x COLS cellular automaton with a run-time selectable toroidal or dead-boundary edge mode.
- Run-time birth/survive rule masks; default is B3/S23.
- Computes one row per cycle through a row-serial FSM rather than a full-grid combinational update, which trades latency for area at large sizes.
- Provides step and free-run control, a generation counter, and stable/extinct status for the display/controller layer above.

---
 rtl/life_pkg.sv | 14 +
 rtl/life_row_eval.sv | 35 +++
 rtl/life_grid_engine.sv | 182 ++++++++++++++++++
 tb/tb_life_grid_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared states, rule defaults and widths for the life grid engine
package life_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } life_state_t;

    localparam logic [8:0] LIFE_BIRTH_DEFAULT   = 9'b000001000;
    localparam logic [8:0] LIFE_SURVIVE_DEFAULT = 9'b000001100;
    localparam int         NBR_W                = 4;

endpackage

// File: rtl/life_row_eval.sv
// rtl/life_row_eval.sv - combinational next-row evaluation: neighbour count and rule lookup per column
module life_row_eval
    import life_pkg::*;
#(
    parameter int COLS = 16
) (
    input  logic [COLS-1:0] row_up,
    input  logic [COLS-1:0] row_cur,
    input  logic [COLS-1:0] row_dn,
    input  logic            wrap,
    input  logic [8:0]      birth_mask,
    input  logic [8:0]      survive_mask,
    output logic [COLS-1:0] row_next
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int CL = (c == 0) ? COLS - 1 : c - 1;
        localparam int CR = (c == COLS - 1) ? 0 : c + 1;

        logic             en_l;
        logic             en_r;
        logic [NBR_W-1:0] n;

        // Edge columns only see their wrapped neighbour in toroidal mode.
        assign en_l = wrap || (c != 0);
        assign en_r = wrap || (c != COLS - 1);

        assign n = NBR_W'(row_up[CL] & en_l) + NBR_W'(row_up[c]) + NBR_W'(row_up[CR] & en_r)
                 + NBR_W'(row_cur[CL] & en_l) + NBR_W'(row_cur[CR] & en_r)
                 + NBR_W'(row_dn[CL] & en_l) + NBR_W'(row_dn[c]) + NBR_W'(row_dn[CR] & en_r);

        assign row_next[c] = row_cur[c] ? survive_mask[n] : birth_mask[n];
    end

endmodule

// File: rtl/life_grid_engine.sv
// rtl/life_grid_engine.sv - row-serial Game of Life engine; LIFE_PERIOD2_DETECT_EN adds osc2 output
module life_grid_engine
    import life_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] data,
    input  logic                 start,
    input  logic                 run,
    input  logic                 wrap,
    input  logic [8:0]           birth_mask,
    input  logic [8:0]           survive_mask,
    output logic [ROWS*COLS-1:0] grid,
    output logic                 busy,
    output logic                 gen_done,
    output logic [GEN_W-1:0]     generation,
    output logic                 stable,
    output logic                 extinct
`ifdef LIFE_PERIOD2_DETECT_EN
    ,
    output logic                 osc2
`endif
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);

    life_state_t     state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [N-1:0]    grid_q, grid_d;
    logic [N-1:0]    next_grid_q, next_grid_d;
    logic            wrap_q, wrap_d;
    logic [8:0]      birth_q, birth_d;
    logic [8:0]      survive_q, survive_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic            gen_done_q, gen_done_d;
    logic            stable_q, stable_d;
    logic            extinct_q, extinct_d;
`ifdef LIFE_PERIOD2_DETECT_EN
    logic [N-1:0]    prev_q, prev_d;
    logic            osc2_q, osc2_d;
`endif

    int              ri;
    logic [COLS-1:0] row_up, row_cur, row_dn, row_next;

    // Neighbour rows of the current pointer; out-of-grid rows read as dead unless wrapping.
    always_comb begin
        int ru;
        int rd;
        ri      = int'(row_q);
        ru      = (ri == 0) ? ROWS - 1 : ri - 1;
        rd      = (ri == ROWS - 1) ? 0 : ri + 1;
        row_cur = grid_q[ri*COLS +: COLS];
        row_up  = grid_q[ru*COLS +: COLS];
        row_dn  = grid_q[rd*COLS +: COLS];
        if (!wrap_q && ri == 0)        row_up = '0;
        if (!wrap_q && ri == ROWS - 1) row_dn = '0;
    end

    life_row_eval #(.COLS(COLS)) u_row_eval (
        .row_up       (row_up),
        .row_cur      (row_cur),
        .row_dn       (row_dn),
        .wrap         (wrap_q),
        .birth_mask   (birth_q),
        .survive_mask (survive_q),
        .row_next     (row_next)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        grid_d      = grid_q;
        next_grid_d = next_grid_q;
        wrap_d      = wrap_q;
        birth_d     = birth_q;
        survive_d   = survive_q;
        gen_d       = gen_q;
        gen_done_d  = 1'b0;
        stable_d    = stable_q;
        extinct_d   = extinct_q;
`ifdef LIFE_PERIOD2_DETECT_EN
        prev_d      = prev_q;
        osc2_d      = osc2_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    grid_d    = data;
                    gen_d     = '0;
                    stable_d  = 1'b0;
                    extinct_d = (data == '0);
`ifdef LIFE_PERIOD2_DETECT_EN
                    prev_d    = '0;
                    osc2_d    = 1'b0;
`endif
                end else if (start || run) begin
                    wrap_d    = wrap;
                    birth_d   = birth_mask;
                    survive_d = survive_mask;
                    row_d     = '0;
                    state_d   = COMPUTE;
                end
            end
            COMPUTE: begin
                next_grid_d[ri*COLS +: COLS] = row_next;
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = COMMIT;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            COMMIT: begin
                grid_d     = next_grid_q;
                gen_d      = gen_q + GEN_W'(1);
                stable_d   = (next_grid_q == grid_q);
                extinct_d  = (next_grid_q == '0);
                gen_done_d = 1'b1;
`ifdef LIFE_PERIOD2_DETECT_EN
                prev_d     = grid_q;
                osc2_d     = (next_grid_q == prev_q) && !(next_grid_q == grid_q);
`endif
                row_d      = '0;
                state_d    = run ? COMPUTE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            grid_q      <= '0;
            next_grid_q <= '0;
            wrap_q      <= 1'b0;
            birth_q     <= '0;
            survive_q   <= '0;
            gen_q       <= '0;
            gen_done_q  <= 1'b0;
            stable_q    <= 1'b0;
            extinct_q   <= 1'b0;
`ifdef LIFE_PERIOD2_DETECT_EN
            prev_q      <= '0;
            osc2_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            grid_q      <= grid_d;
            next_grid_q <= next_grid_d;
            wrap_q      <= wrap_d;
            birth_q     <= birth_d;
            survive_q   <= survive_d;
            gen_q       <= gen_d;
            gen_done_q  <= gen_done_d;
            stable_q    <= stable_d;
            extinct_q   <= extinct_d;
`ifdef LIFE_PERIOD2_DETECT_EN
            prev_q      <= prev_d;
            osc2_q      <= osc2_d;
`endif
        end
    end

    assign grid       = grid_q;
    assign busy       = (state_q != IDLE);
    assign gen_done   = gen_done_q;
    assign generation = gen_q;
    assign stable     = stable_q;
    assign extinct    = extinct_q;
`ifdef LIFE_PERIOD2_DETECT_EN
    assign osc2       = osc2_q;
`endif

endmodule

// File: tb/tb_life_grid_engine.sv
// tb/tb_life_grid_engine.sv - directed self-checking bench for life_grid_engine (16x16)
module tb_life_grid_engine;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int GEN_W = 16;
    localparam int N     = ROWS * COLS;

    logic             clk;
    logic             reset;
    logic             load;
    logic [N-1:0]     data;
    logic             start;
    logic             run;
    logic             wrap;
    logic [8:0]       birth_mask;
    logic [8:0]       survive_mask;
    logic [N-1:0]     grid;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] generation;
    logic             stable;
    logic             extinct;

    int checks = 0;
    int errors = 0;

    life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .data         (data),
        .start        (start),
        .run          (run),
        .wrap         (wrap),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .grid         (grid),
        .busy         (busy),
        .gen_done     (gen_done),
        .generation   (generation),
        .stable       (stable),
        .extinct      (extinct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_load(input logic [N-1:0] img);
        @(negedge clk);
        load = 1'b1;
        data = img;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!gen_done && cyc < 200);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (grid !== '0 || busy !== 1'b0 || gen_done !== 1'b0 || generation !== '0 ||
            stable !== 1'b0 || extinct !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: grid=%h busy=%b gd=%b gen=%0d st=%b ex=%b, expected all 0",
                     grid, busy, gen_done, generation, stable, extinct);
        end
        reset = 1'b0;
        do_load('0);
        checks++;
        if (extinct !== 1'b1) begin
            errors++;
            $display("FAIL load_zero_extinct: extinct=%b expected 1", extinct);
        end
    endtask

    task automatic test_blinker();
        logic [N-1:0] h, v;
        int cyc;
        h = '0; v = '0;
        h[5*COLS+4] = 1'b1; h[5*COLS+5] = 1'b1; h[5*COLS+6] = 1'b1;
        v[4*COLS+5] = 1'b1; v[5*COLS+5] = 1'b1; v[6*COLS+5] = 1'b1;
        wrap = 1'b1;
        do_load(h);
        do_start();
        wait_done(cyc);
        checks++;
        if (cyc != ROWS + 1) begin
            errors++;
            $display("FAIL blinker_latency: got %0d cycles expected %0d", cyc, ROWS + 1);
        end
        checks++;
        if (grid !== v) begin
            errors++;
            $display("FAIL blinker_grid: got %h expected %h", grid, v);
        end
        checks++;
        if (generation !== 16'd1 || stable !== 1'b0 || extinct !== 1'b0) begin
            errors++;
            $display("FAIL blinker_status: gen=%0d st=%b ex=%b expected 1 0 0", generation, stable, extinct);
        end
        @(negedge clk);
        checks++;
        if (gen_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL blinker_pulse: gen_done=%b busy=%b expected 0 0", gen_done, busy);
        end
    endtask

    task automatic test_block();
        logic [N-1:0] b, k;
        int cyc;
        b = '0; k = '0;
        b[0] = 1'b1; b[1] = 1'b1; b[COLS] = 1'b1; b[COLS+1] = 1'b1;
        k[0] = 1'b1; k[COLS-1] = 1'b1; k[(ROWS-1)*COLS] = 1'b1; k[N-1] = 1'b1;
        wrap = 1'b0;
        do_load(b);
        do_start();
        wait_done(cyc);
        checks++;
        if (grid !== b || stable !== 1'b1) begin
            errors++;
            $display("FAIL block_nowrap: grid=%h stable=%b expected %h 1", grid, stable, b);
        end
        wrap = 1'b1;
        do_load(k);
        do_start();
        wait_done(cyc);
        checks++;
        if (grid !== k || stable !== 1'b1) begin
            errors++;
            $display("FAIL block_corner_wrap: grid=%h stable=%b expected %h 1", grid, stable, k);
        end
        wrap = 1'b0;
        do_load(k);
        do_start();
        wait_done(cyc);
        checks++;
        if (grid !== '0 || extinct !== 1'b1) begin
            errors++;
            $display("FAIL corner_nowrap_dies: grid=%h extinct=%b expected 0 1", grid, extinct);
        end
    endtask

    task automatic test_rules();
        logic [N-1:0] s, e;
        int cyc;
        s = '0; e = '0;
        s[8*COLS+8] = 1'b1;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) e[(8+dr)*COLS+(8+dc)] = 1'b1;
        wrap = 1'b0;
        birth_mask = 9'b000000010;
        survive_mask = 9'b0;
        do_load(s);
        do_start();
        wait_done(cyc);
        checks++;
        if (grid !== e) begin
            errors++;
            $display("FAIL b1_s_none: got %h expected %h", grid, e);
        end
        birth_mask = 9'b000001000;
        survive_mask = 9'b000001100;
        do_load(s);
        do_start();
        wait_done(cyc);
        checks++;
        if (grid !== '0 || extinct !== 1'b1 || stable !== 1'b0) begin
            errors++;
            $display("FAIL lone_cell: grid=%h ex=%b st=%b expected 0 1 0", grid, extinct, stable);
        end
    endtask

    task automatic test_ignore_busy();
        logic [N-1:0] h, v, k;
        int cyc;
        h = '0; v = '0; k = '0;
        h[5*COLS+4] = 1'b1; h[5*COLS+5] = 1'b1; h[5*COLS+6] = 1'b1;
        v[4*COLS+5] = 1'b1; v[5*COLS+5] = 1'b1; v[6*COLS+5] = 1'b1;
        k[0] = 1'b1; k[1] = 1'b1;
        wrap = 1'b1;
        do_load(h);
        do_start();
        repeat (3) @(negedge clk);
        load = 1'b1;
        data = k;
        start = 1'b1;
        birth_mask = 9'b0;
        wrap = 1'b0;
        @(negedge clk);
        load = 1'b0;
        start = 1'b0;
        birth_mask = 9'b000001000;
        wrap = 1'b1;
        wait_done(cyc);
        checks++;
        if (grid !== v || generation !== 16'd1) begin
            errors++;
            $display("FAIL ignore_busy: grid=%h gen=%0d expected %h 1", grid, generation, v);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || generation !== 16'd1) begin
            errors++;
            $display("FAIL ignore_busy_idle: busy=%b gen=%0d expected 0 1", busy, generation);
        end
    endtask

    task automatic test_glider_run();
        logic [N-1:0] g;
        int gens, cyc, last, period;
        g = '0;
        g[0*COLS+1] = 1'b1; g[1*COLS+2] = 1'b1;
        g[2*COLS+0] = 1'b1; g[2*COLS+1] = 1'b1; g[2*COLS+2] = 1'b1;
        wrap = 1'b1;
        do_load(g);
        @(negedge clk);
        run = 1'b1;
        gens = 0; cyc = 0; last = 0; period = 0;
        while (gens < 64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (gen_done) begin
                gens++;
                if (gens == 2) period = cyc - last;
                last = cyc;
                if (gens == 63) run = 1'b0;
            end
        end
        run = 1'b0;
        checks++;
        if (gens != 64) begin
            errors++;
            $display("FAIL glider_timeout: saw %0d generations expected 64", gens);
        end
        checks++;
        if (period != ROWS + 1) begin
            errors++;
            $display("FAIL run_throughput: period %0d expected %0d", period, ROWS + 1);
        end
        checks++;
        if (grid !== g || generation !== 16'd64) begin
            errors++;
            $display("FAIL glider_64: grid=%h gen=%0d expected %h 64", grid, generation, g);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || generation !== 16'd64) begin
            errors++;
            $display("FAIL run_stop: busy=%b gen=%0d expected 0 64", busy, generation);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] h;
        int cyc, seen;
        h = '0;
        h[5*COLS+4] = 1'b1; h[5*COLS+5] = 1'b1; h[5*COLS+6] = 1'b1;
        wrap = 1'b1;
        do_load(h);
        do_start();
        wait_done(cyc);
        do_start();
        repeat (7) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (grid !== '0 || busy !== 1'b0 || generation !== '0 || stable !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: grid=%h busy=%b gen=%0d st=%b expected 0 0 0 0",
                     grid, busy, generation, stable);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (gen_done || busy) seen++;
        end
        checks++;
        if (seen != 0 || grid !== '0) begin
            errors++;
            $display("FAIL reset_idle: activity=%0d grid=%h expected 0 0", seen, grid);
        end
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        data = '0;
        start = 1'b0;
        run = 1'b0;
        wrap = 1'b0;
        birth_mask = 9'b000001000;
        survive_mask = 9'b000001100;
        test_reset();
        test_blinker();
        test_block();
        test_rules();
        test_ignore_busy();
        test_glider_run();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
